// File: rtl/fifo_rd_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_unpack
// Brief    : Drains 16-bit words from a non-show-ahead FIFO and emits them as
//            a byte stream on valid/ready. Optional statistics port under
//            FIFO_RD_UNPACK_STAT_EN (byte_cnt, ovf_seen).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_unpack #(
  parameter int HI_FIRST = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic        rdempty,
  input  logic [15:0] q,
  output logic        rdreq,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
`ifdef FIFO_RD_UNPACK_STAT_EN
  output logic [31:0] byte_cnt,
  output logic        ovf_seen,
`endif
  output logic        busy
);

  localparam logic c_hi_first = (HI_FIRST != 0);

  logic [15:0] r_cur;
  logic        r_cur_v;
  logic [15:0] r_nxt;
  logic        r_nxt_v;
  logic        r_sel;
  logic        r_pend;
  logic [7:0]  r_dout;
  logic        r_dout_valid;

  logic        w_take;
  logic        w_wdone;
  logic [1:0]  w_occ;
  logic        w_rdreq;
  logic [15:0] w_cur_n;
  logic        w_cur_v_n;
  logic [15:0] w_nxt_n;
  logic        w_nxt_v_n;
  logic        w_sel_n;
  logic [7:0]  w_byte;

  assign w_take  = r_dout_valid & dout_ready;
  assign w_wdone = w_take & r_sel;

  // wdone implies cur_v, so the subtraction never underflows.
  assign w_occ   = {1'b0, r_cur_v} + {1'b0, r_nxt_v} + {1'b0, r_pend} - {1'b0, w_wdone};
  assign w_rdreq = ~sys_rst & en & ~rdempty & (w_occ < 2'd2);

  always_comb begin
    w_cur_n   = r_cur;
    w_cur_v_n = r_cur_v;
    w_nxt_n   = r_nxt;
    w_nxt_v_n = r_nxt_v;
    w_sel_n   = r_sel;
    if (w_wdone) begin
      w_cur_n   = r_nxt;
      w_cur_v_n = r_nxt_v;
      w_nxt_v_n = 1'b0;
      w_sel_n   = 1'b0;
    end else if (w_take) begin
      w_sel_n   = 1'b1;
    end
    // Returning word fills the oldest free slot so byte order is preserved.
    if (r_pend) begin
      if (!w_cur_v_n) begin
        w_cur_n   = q;
        w_cur_v_n = 1'b1;
        w_sel_n   = 1'b0;
      end else if (!w_nxt_v_n) begin
        w_nxt_n   = q;
        w_nxt_v_n = 1'b1;
      end
    end
    w_byte = (w_sel_n == c_hi_first) ? w_cur_n[7:0] : w_cur_n[15:8];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cur        <= 16'h0000;
      r_cur_v      <= 1'b0;
      r_nxt        <= 16'h0000;
      r_nxt_v      <= 1'b0;
      r_sel        <= 1'b0;
      r_pend       <= 1'b0;
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
    end else begin
      r_cur        <= w_cur_n;
      r_cur_v      <= w_cur_v_n;
      r_nxt        <= w_nxt_n;
      r_nxt_v      <= w_nxt_v_n;
      r_sel        <= w_sel_n;
      r_pend       <= w_rdreq;
      r_dout       <= w_byte;
      r_dout_valid <= w_cur_v_n;
    end
  end

  assign rdreq      = w_rdreq;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_cur_v | r_nxt_v | r_pend;

`ifdef FIFO_RD_UNPACK_STAT_EN
  logic [31:0] r_byte_cnt;
  logic        r_ovf_seen;
  logic        w_ovf;

  // Both slots still full after the shift while a word returns.
  assign w_ovf = r_pend & r_cur_v & r_nxt_v & ~w_wdone;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_byte_cnt <= 32'h0000_0000;
      r_ovf_seen <= 1'b0;
    end else begin
      if (w_take) begin
        r_byte_cnt <= r_byte_cnt + 32'd1;
      end
      if (w_ovf) begin
        r_ovf_seen <= 1'b1;
      end
    end
  end

  assign byte_cnt = r_byte_cnt;
  assign ovf_seen = r_ovf_seen;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_unpack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fifo_rd_unpack
// Brief    : Self-checking bench: FIFO model, directed vector table, corner
//            sequences and randomized traffic against a word/byte-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_unpack;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dout_ready;
  logic        force_empty;
  logic [15:0] q;
  logic        rdempty;
  logic        rdreq_hi, rdreq_lo;
  logic [7:0]  dout_hi, dout_lo;
  logic        valid_hi, valid_lo;
  logic        busy_hi, busy_lo;
`ifdef FIFO_RD_UNPACK_STAT_EN
  logic [31:0] byte_cnt_hi, byte_cnt_lo;
  logic        ovf_hi, ovf_lo;
`endif

  logic [15:0] mem [0:4095];
  int          wr_idx = 0;
  int          rd_idx = 0;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard state: words popped, bytes accepted (absolute stream index).
  int m_issued = 0;
  int m_acc    = 0;
  int m_pend   = 0;
  int acc_since_rst = 0;
  bit stall_prev = 0;
  logic [7:0] prev_dout = 8'h00;

  fifo_rd_unpack #(.HI_FIRST(1)) u_dut_hi (
    .sys_clk(clk), .sys_rst(rst), .en(en), .rdempty(rdempty), .q(q),
    .rdreq(rdreq_hi), .dout(dout_hi), .dout_valid(valid_hi),
    .dout_ready(dout_ready),
`ifdef FIFO_RD_UNPACK_STAT_EN
    .byte_cnt(byte_cnt_hi), .ovf_seen(ovf_hi),
`endif
    .busy(busy_hi)
  );

  fifo_rd_unpack #(.HI_FIRST(0)) u_dut_lo (
    .sys_clk(clk), .sys_rst(rst), .en(en), .rdempty(rdempty), .q(q),
    .rdreq(rdreq_lo), .dout(dout_lo), .dout_valid(valid_lo),
    .dout_ready(dout_ready),
`ifdef FIFO_RD_UNPACK_STAT_EN
    .byte_cnt(byte_cnt_lo), .ovf_seen(ovf_lo),
`endif
    .busy(busy_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-show-ahead FIFO: q updates on the edge that sees rdreq.
  assign rdempty = force_empty | (rd_idx == wr_idx);
  always @(posedge clk) begin
    if (rdreq_hi) begin
      q      <= mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k, input bit hi);
    logic [15:0] w;
    w = mem[k / 2];
    if (((k % 2) == 0) == hi) return w[15:8];
    return w[7:0];
  endfunction

  task automatic push(input logic [15:0] w);
    mem[wr_idx] = w;
    wr_idx++;
  endtask

  // Continuous model check, sampled mid-cycle after inputs settle.
  always @(negedge clk) begin
    int committed, landed, occ;
    bit take, wdone, exp_rdreq;
    #2;
    if (rst) begin
      m_acc         = 2 * m_issued;
      m_pend        = 0;
      acc_since_rst = 0;
      stall_prev    = 0;
    end else begin
      committed = m_issued - m_acc / 2;
      landed    = committed - m_pend;
      check("busy_hi", busy_hi, committed != 0);
      check("busy_lo", busy_lo, committed != 0);
      check("valid_hi", valid_hi, landed > 0);
      check("valid_lo", valid_lo, landed > 0);
      if (landed > 0) begin
        check("dout_hi", dout_hi, exp_byte(m_acc, 1'b1));
        check("dout_lo", dout_lo, exp_byte(m_acc, 1'b0));
      end
      if (stall_prev) check("hold", dout_hi, prev_dout);
      take      = (landed > 0) && dout_ready;
      wdone     = take && (m_acc % 2 == 1);
      occ       = committed - int'(wdone);
      exp_rdreq = en && !rdempty && (occ < 2);
      check("rdreq_hi", rdreq_hi, exp_rdreq);
      check("rdreq_lo", rdreq_lo, exp_rdreq);
      m_issued  += int'(rdreq_hi);
      m_pend     = int'(rdreq_hi);
      stall_prev = (landed > 0) && !dout_ready;
      prev_dout  = dout_hi;
      if (take) begin
        m_acc++;
        acc_since_rst++;
      end
    end
  end

  typedef struct {
    logic       valid;
    logic [7:0] d_hi;
    logic [7:0] d_lo;
    logic       busy;
    logic       rdreq;
  } vec_t;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdreq"}, rdreq_hi, 1'b0);
    check({tag, "_dout"},  dout_hi,  8'h00);
    check({tag, "_valid"}, valid_hi, 1'b0);
    check({tag, "_busy"},  busy_hi,  1'b0);
  endtask

  task automatic wait_drain(input int limit, input string tag);
    int cyc;
    cyc = 0;
    while (!(m_acc == 2 * wr_idx && !busy_hi) && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, cyc < limit, 1'b1);
  endtask

  initial begin
    vec_t tbl [7];
    int   base;
    int   cyc;
    tbl[0] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 8'hA1, 8'hB2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'hB2, 8'hA1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'hC3, 8'hD4, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'hD4, 8'hC3, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b0; dout_ready = 1'b0; force_empty = 1'b0;
    #1;
    check_reset_outputs("init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two-word burst, latency and order for both byte orders.
    dout_ready = 1'b1;
    push(16'hA1B2);
    push(16'hC3D4);
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      check($sformatf("vec%0d_valid", i), valid_hi, tbl[i].valid);
      check($sformatf("vec%0d_busy", i),  busy_hi,  tbl[i].busy);
      check($sformatf("vec%0d_rdreq", i), rdreq_hi, tbl[i].rdreq);
      if (tbl[i].valid) begin
        check($sformatf("vec%0d_dhi", i), dout_hi, tbl[i].d_hi);
        check($sformatf("vec%0d_dlo", i), dout_lo, tbl[i].d_lo);
      end
      @(negedge clk);
    end

    // Eight words with ready pattern 1,0,0 repeating.
    base = m_acc;
    for (int i = 0; i < 8; i++) push(16'($urandom));
    cyc = 0;
    while (m_acc - base < 16 && cyc < 200) begin
      dout_ready = (cyc % 3 == 0);
      @(negedge clk);
      cyc++;
    end
    check("toggle_bytes", m_acc - base, 16);
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("toggle_idle", busy_hi, 1'b0);

    // Single word, FIFO then empty: exactly two bytes.
    base = m_acc;
    push(16'h5A3C);
    repeat (12) @(negedge clk);
    #1;
    check("single_bytes", m_acc - base, 2);
    check("single_valid", valid_hi, 1'b0);
    check("single_rdreq", rdreq_hi, 1'b0);
    @(negedge clk);

    // Reset while a word is held and another is in flight.
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'($urandom));
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_valid", valid_hi, 1'b1);
    check("pre_rst_busy",  busy_hi,  1'b1);
    rst = 1'b1;
    force_empty = 1'b1;
    #1;
    check_reset_outputs("midrst");
`ifdef FIFO_RD_UNPACK_STAT_EN
    check("midrst_cnt", byte_cnt_hi, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", valid_hi, 1'b0);
    end
    force_empty = 1'b0;
    wait_drain(200, "post_rst_drain");

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (($urandom % 2 == 0) && wr_idx < 4000) push(16'($urandom));
      dout_ready  = ($urandom % 4) != 0;
      en          = ($urandom % 8) != 0;
      force_empty = ($urandom % 10) == 0;
    end
    @(negedge clk);
    en = 1'b1; dout_ready = 1'b1; force_empty = 1'b0;
    wait_drain(10000, "rand_drain");
    check("all_bytes", m_acc - 2 * m_issued, 0);
    check("fifo_empty", rd_idx, wr_idx);

`ifdef FIFO_RD_UNPACK_STAT_EN
    check("byte_cnt_min300", acc_since_rst >= 300, 1'b1);
    check("byte_cnt_hi", byte_cnt_hi, acc_since_rst);
    check("byte_cnt_lo", byte_cnt_lo, acc_since_rst);
    check("ovf_hi", ovf_hi, 1'b0);
    check("ovf_lo", ovf_lo, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
